lbp_hist: RTL and testbench

//   Downstream consumer of the LBP engine's result-write stream (lbp_valid/lbp_addr/lbp_data).

---
 rtl/lbp_hist.sv | 114 +++++++++++
 tb/tb_lbp_hist.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
// 256-bin histogram of LBP codes for one frame; bins stream out (and self-clear) on finish.
// Optional LBP_HIST_BORDER_SKIP_EN: strobes on the outermost row/column ring are not counted.
module lbp_hist #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lbp_valid,
    input  logic [ADDR_W-1:0] lbp_addr,
    input  logic [7:0]        lbp_data,
    input  logic              finish,
    output logic              hist_valid,
    input  logic              hist_ready,
    output logic [7:0]        hist_bin,
    output logic [CNT_W-1:0]  hist_cnt,
    output logic              hist_done,
    output logic              drop
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = ADDR_W - COL_W;

    typedef enum logic {ACCUM, READOUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bins_q [256];
    logic [CNT_W-1:0] bins_d [256];
    logic [7:0]       ptr_q, ptr_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic             in_frame;
    logic             count_en;
    logic             xfer;

`ifdef LBP_HIST_BORDER_SKIP_EN
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    assign col      = lbp_addr[COL_W-1:0];
    assign row      = lbp_addr[ADDR_W-1:COL_W];
    assign in_frame = (row != '0) && (row != ROW_W'(IMG_H - 1)) &&
                      (col != '0) && (col != COL_W'(IMG_W - 1));
`else
    logic unused_addr;
    assign unused_addr = ^lbp_addr;
    assign in_frame    = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        bins_d   = bins_q;
        ptr_d    = ptr_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        drop_d   = drop_q;
        count_en = 1'b0;
        xfer     = valid_q & hist_ready;
        case (state_q)
            ACCUM: begin
                count_en = lbp_valid & in_frame;
                if (finish) begin
                    state_d = READOUT;
                    valid_d = 1'b1;
                    ptr_d   = 8'd0;
                end
            end
            READOUT: begin
                if (lbp_valid) drop_d = 1'b1;
                // Clearing on readout leaves an empty histogram for the next frame.
                if (xfer) begin
                    bins_d[ptr_q] = '0;
                    ptr_d         = ptr_q + 8'd1;
                    if (ptr_q == 8'hFF) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
        // Single-cycle read-modify-write on flops, so back-to-back hits never collide.
        if (count_en && (bins_q[lbp_data] != {CNT_W{1'b1}}))
            bins_d[lbp_data] = bins_q[lbp_data] + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ACCUM;
            ptr_q   <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < 256; i++) bins_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
            bins_q  <= bins_d;
        end
    end

    assign hist_valid = valid_q;
    assign hist_bin   = ptr_q;
    assign hist_cnt   = valid_q ? bins_q[ptr_q] : '0;
    assign hist_done  = done_q;
    assign drop       = drop_q;

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: a wide (CNT_W=15) and a narrow (CNT_W=4) instance share stimulus.
module tb_lbp_hist;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        lbp_valid = 1'b0;
    logic [13:0] lbp_addr = '0;
    logic [7:0]  lbp_data = '0;
    logic        finish = 1'b0;
    logic        hist_ready = 1'b0;

    logic        w_valid, w_done, w_drop;
    logic [7:0]  w_bin;
    logic [14:0] w_cnt;
    logic        n_valid, n_done, n_drop;
    logic [7:0]  n_bin;
    logic [3:0]  n_cnt;

    lbp_hist #(.CNT_W(15)) dut_w (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(w_valid), .hist_ready(hist_ready),
        .hist_bin(w_bin), .hist_cnt(w_cnt), .hist_done(w_done), .drop(w_drop));

    lbp_hist #(.CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(n_valid), .hist_ready(hist_ready),
        .hist_bin(n_bin), .hist_cnt(n_cnt), .hist_done(n_done), .drop(n_drop));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bin;
        logic [14:0] cnt;
    } exp_t;

    exp_t        q_w[$];
    exp_t        q_n[$];
    int          model[256];
    int          vec = 0;
    int          miss = 0;
    int          rdy_mode = 0;
    bit          hold_v[2];
    logic [7:0]  hold_b[2];
    logic [14:0] hold_c[2];
    bit          done_exp[2];
    int          done_seen[2];

    function automatic bit on_border(input logic [13:0] a);
`ifdef LBP_HIST_BORDER_SKIP_EN
        return (a[13:7] == 7'd0) || (a[13:7] == 7'd127) || (a[6:0] == 7'd0) || (a[6:0] == 7'd127);
`else
        return a[0] & 1'b0;
`endif
    endfunction

    // hist_ready changes 2 time units after posedge so the negedge monitor sees a settled value
    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       hist_ready = 1'b1;
            1:       hist_ready = 1'($urandom_range(0, 1));
            default: hist_ready = 1'b0;
        endcase
    end

    task automatic check_port(input int d, input logic v, input logic [7:0] b,
                              input logic [14:0] c, input logic dn);
        exp_t e;
        bit   empty;
        if (done_exp[d]) begin
            vec++;
            if (dn !== 1'b1 || v !== 1'b0) begin
                miss++;
                $display("FAIL done[%0d]: got done=%b valid=%b, need done=1 valid=0", d, dn, v);
            end
            done_exp[d] = 1'b0;
        end else if (dn !== 1'b0) begin
            vec++;
            miss++;
            $display("FAIL spurious_done[%0d]: got done=%b, need 0", d, dn);
        end
        if (dn === 1'b1) done_seen[d]++;
        if (hold_v[d]) begin
            vec++;
            if (v !== 1'b1 || b !== hold_b[d] || c !== hold_c[d]) begin
                miss++;
                $display("FAIL hold[%0d]: got v=%b bin=%0d cnt=%0d, need v=1 bin=%0d cnt=%0d",
                         d, v, b, c, hold_b[d], hold_c[d]);
            end
            hold_v[d] = 1'b0;
        end
        if (v === 1'b1 && hist_ready === 1'b1) begin
            empty = (d == 0) ? (q_w.size() == 0) : (q_n.size() == 0);
            vec++;
            if (empty) begin
                miss++;
                $display("FAIL extra_xfer[%0d]: got bin=%0d cnt=%0d, need no transfer", d, b, c);
            end else begin
                if (d == 0) e = q_w.pop_front();
                else        e = q_n.pop_front();
                if (b !== e.bin || c !== e.cnt) begin
                    miss++;
                    $display("FAIL bin[%0d]: got bin=%0d cnt=%0d, need bin=%0d cnt=%0d",
                             d, b, c, e.bin, e.cnt);
                end
                if (e.bin == 8'hFF) done_exp[d] = 1'b1;
            end
        end else if (v === 1'b1) begin
            hold_v[d] = 1'b1;
            hold_b[d] = b;
            hold_c[d] = c;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            hold_v   = '{1'b0, 1'b0};
            done_exp = '{1'b0, 1'b0};
        end else begin
            check_port(0, w_valid, w_bin, w_cnt, w_done);
            check_port(1, n_valid, n_bin, {11'd0, n_cnt}, n_done);
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d, need %0d", nm, got, exp);
        end
    endtask

    task automatic strobe(input logic [13:0] a, input logic [7:0] dat, input bit cnt);
        lbp_valid = 1'b1;
        lbp_addr  = a;
        lbp_data  = dat;
        if (cnt && !on_border(a)) model[dat]++;
        @(posedge clk);
        #1;
        lbp_valid = 1'b0;
    endtask

    task automatic push_expected();
        exp_t e;
        for (int b = 0; b < 256; b++) begin
            e.bin = 8'(b);
            e.cnt = 15'(model[b]);
            q_w.push_back(e);
            e.cnt = (model[b] > 15) ? 15'd15 : 15'(model[b]);
            q_n.push_back(e);
            model[b] = 0;
        end
    endtask

    // Optional strobe in the finish cycle exercises the "counted on finish" latency rule.
    task automatic do_finish(input bit with_strobe, input logic [13:0] a, input logic [7:0] dat);
        finish = 1'b1;
        if (with_strobe) begin
            lbp_valid = 1'b1;
            lbp_addr  = a;
            lbp_data  = dat;
            if (!on_border(a)) model[dat]++;
        end
        @(posedge clk);
        #1;
        finish    = 1'b0;
        lbp_valid = 1'b0;
        push_expected();
    endtask

    task automatic wait_readout(input string nm);
        int d0 = done_seen[0];
        int d1 = done_seen[1];
        int t  = 0;
        while ((done_seen[0] == d0 || done_seen[1] == d1) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        #1;
        vec++;
        if (t >= 5000) begin
            miss++;
            $display("FAIL %s_timeout: got no hist_done in %0d cycles, need one", nm, t);
        end
        chk({nm, "_q_empty"}, 32'(q_w.size() + q_n.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        q_w.delete();
        q_n.delete();
        for (int b = 0; b < 256; b++) model[b] = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        // T1: reset state, then an empty frame
        do_reset(2);
        chk("rst_valid", 32'(w_valid), 0);
        chk("rst_bin", 32'(w_bin), 0);
        chk("rst_cnt", 32'(w_cnt), 0);
        chk("rst_done", 32'(w_done), 0);
        chk("rst_drop", 32'(w_drop), 0);
        chk("rst_n_valid", 32'(n_valid), 0);
        reset = 1'b1;
        do_finish(1'b0, '0, '0);
        wait_readout("t1");
        chk("t1_drop", 32'(w_drop), 0);

        // T2: full frame of code 0 (narrow instance saturates at 15)
        rdy_mode = 0;
        for (int a = 0; a < 16384; a++) strobe(14'(a), 8'h00, 1'b1);
`ifdef LBP_HIST_BORDER_SKIP_EN
        chk("t2_model_bin0", 32'(model[0]), 15876);
`else
        chk("t2_model_bin0", 32'(model[0]), 16384);
`endif
        do_finish(1'b0, '0, '0);
        wait_readout("t2");

        // T3: same-bin burst plus a strobe on the finish cycle, random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) strobe(14'(129 + i), 8'hA5, 1'b1);
        do_finish(1'b1, 14'd140, 8'h01);
        wait_readout("t3");

        // T4: mixed codes under backpressure, then a second finish with nothing new
        for (int i = 0; i < 300; i++) strobe(14'(258 + i), 8'(i) ^ 8'h3C, 1'b1);
        do_finish(1'b0, '0, '0);
        wait_readout("t4a");
        do_finish(1'b0, '0, '0);
        wait_readout("t4b");

        // T5: 20 hits on bin 3 -> 20 wide, 15 narrow
        for (int i = 0; i < 20; i++) strobe(14'd300, 8'h03, 1'b1);
        do_finish(1'b0, '0, '0);
        wait_readout("t5");
        chk("t5_drop", 32'(w_drop), 0);

        // T6: abort the readout at bin 100
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) strobe(14'd400, 8'h09, 1'b1);
        do_finish(1'b0, '0, '0);
        t = 0;
        while (!(w_valid === 1'b1 && w_bin == 8'd100) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("t6_reach_bin100", 32'(t < 2000), 1);
        rdy_mode = 2;
        do_reset(1);
        reset = 1'b1;
        chk("t6_valid", 32'(w_valid), 0);
        chk("t6_done", 32'(w_done), 0);
        chk("t6_bin", 32'(w_bin), 0);
        chk("t6_n_valid", 32'(n_valid), 0);
        repeat (5) @(posedge clk);
        #1;
        rdy_mode = 1;
        do_finish(1'b0, '0, '0);
        wait_readout("t6a");

        // T6: strobe during readout is dropped and flagged
        chk("t6_drop_pre", 32'(w_drop), 0);
        do_finish(1'b0, '0, '0);
        strobe(14'd500, 8'h07, 1'b0);
        chk("t6_drop_w", 32'(w_drop), 1);
        chk("t6_drop_n", 32'(n_drop), 1);
        wait_readout("t6b");
        chk("t6_drop_sticky", 32'(w_drop), 1);
        do_reset(1);
        reset = 1'b1;
        chk("t6_drop_clr", 32'(w_drop), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
